// File: rtl/lsu_ctrl.sv
// Load/store controller: turns one byte-addressed load/store into 32-bit word
// accesses, with read-modify-write for sub-word stores and early rejection of bad requests.
module lsu_ctrl #(
    parameter int MEM_AW = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen
);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WR,
        RESP
    } state_t;

    state_t state, state_next;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        accept;

    // Size/alignment/range screening of an incoming request.
    function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] waddr;
        logic        out_of_range;
        waddr        = {2'b00, addr[31:2]};
        out_of_range = (waddr >> MEM_AW) != 32'd0;
        case (size)
            2'b00:   req_bad = out_of_range;
            2'b01:   req_bad = out_of_range | addr[0];
            2'b10:   req_bad = out_of_range | (addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] merged;
        merged = word;
        case (size)
            2'b00: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
        store_merge = merged;
    endfunction

    assign accept = req_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            word_q       <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == RD2) word_q <= mem_rdata;
            // Response registers only change on entry to RESP, so they hold between responses.
            if (state_next == RESP) begin
                resp_err_q   <= (state == IDLE);
                resp_rdata_q <= (state == RD2 && !we_q)
                                ? load_extract(mem_rdata, size_q, addr_q[1:0], uns_q) : 32'd0;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wen    = 1'b0;
        mem_wdata  = 32'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad(req_size, req_addr))          state_next = RESP;
                    else if (req_we && req_size == 2'b10)     state_next = WR;
                    else                                      state_next = RD1;
                end
            end
            RD1:  state_next = RD2;
            RD2:  state_next = we_q ? WR : RESP;
            WR: begin
                mem_wen    = 1'b1;
                mem_wdata  = store_merge(word_q, wdata_q, size_q, addr_q[1:0]);
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_raddr  = {2'b00, addr_q[31:2]};
    assign mem_waddr  = {2'b00, addr_q[31:2]};
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl (MEM_AW = 4): directed literal cases plus random traffic
// compared every cycle against a transaction-level model with its own memory image.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wen;

    int checks = 0;
    int errors = 0;
    logic chk_en;
    logic seeding;

    lsu_ctrl #(.MEM_AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wen(mem_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        logic [31:0] k;
        k = i + 1;
        return 32'h9E3779B9 * k;
    endfunction

    // Memory attached to the DUT.
    logic [31:0] env_mem [16];
    assign mem_rdata = env_mem[mem_raddr[3:0]];

    always @(posedge clk) begin
        if (seeding) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
        end else if (mem_wen) begin
            env_mem[mem_waddr[3:0]] <= mem_wdata;
        end
    end

    // Reference rules, stated as plain arithmetic on a byte address.
    function automatic logic f_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
               || ((a >> 2) >= 32'd16);
    endfunction

    function automatic int f_lat(input logic we, input logic [1:0] sz, input logic [31:0] a);
        if (f_err(sz, a)) return 1;
        if (we && sz == 2'd2) return 2;
        if (we) return 4;
        return 3;
    endfunction

    function automatic int f_wcyc(input logic we, input logic [1:0] sz, input logic [31:0] a);
        if (f_err(sz, a) || !we) return 0;
        return (sz == 2'd2) ? 1 : 3;
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic u, input logic [31:0] a);
        logic [31:0] v;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            v = (w >> sh) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            sh = 16 * int'(a[1]);
            v = (w >> sh) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] wd, input logic [31:0] a);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
            return (w & ~mask) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'd1) begin
            sh = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    // Transaction model: ph counts cycles since accept (0 = ready for a new request).
    logic [31:0] model_mem [16];
    int          ph = 0;
    int          m_lat = 0;
    int          m_wcyc = 0;
    logic [31:0] m_wa, m_wword, m_rdata;
    logic [31:0] exp_rdata, exp_addr;
    logic        exp_err;

    always @(posedge clk) begin
        if (seeding) begin
            for (int i = 0; i < 16; i++) model_mem[i] <= init_val(i);
        end else if (ph != 0 && ph == m_wcyc) begin
            model_mem[m_wa[3:0]] <= m_wword;
        end
        if (!rst_n) begin
            ph        <= 0;
            m_lat     <= 0;
            m_wcyc    <= 0;
            exp_rdata <= 32'd0;
            exp_err   <= 1'b0;
            exp_addr  <= 32'd0;
        end else if (ph == 0) begin
            if (req_valid) begin
                ph       <= 1;
                m_lat    <= f_lat(req_we, req_size, req_addr);
                m_wcyc   <= f_wcyc(req_we, req_size, req_addr);
                m_wa     <= req_addr >> 2;
                exp_addr <= req_addr >> 2;
                m_wword  <= f_merge(model_mem[req_addr[5:2]], req_size, req_wdata, req_addr);
                m_rdata  <= (req_we || f_err(req_size, req_addr)) ? 32'd0
                            : f_load(model_mem[req_addr[5:2]], req_size, req_unsigned, req_addr);
                if (f_err(req_size, req_addr)) begin
                    exp_err   <= 1'b1;
                    exp_rdata <= 32'd0;
                end
            end
        end else if (ph == m_lat) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
            if (ph + 1 == m_lat) begin
                exp_rdata <= m_rdata;
                exp_err   <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk1("req_ready", req_ready, ph == 0);
                chk1("resp_valid", resp_valid, ph != 0 && ph == m_lat);
                chk1("mem_wen", mem_wen, ph != 0 && ph == m_wcyc);
                chk("mem_raddr", mem_raddr, exp_addr);
                chk("mem_waddr", mem_waddr, exp_addr);
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk1("resp_err", resp_err, exp_err);
                if (ph != 0 && ph == m_wcyc) chk("mem_wdata", mem_wdata, m_wword);
            end
        end
    end

    task automatic chk_reset_outputs(input string name);
        chk1({name, ".req_ready"}, req_ready, 1'b1);
        chk1({name, ".resp_valid"}, resp_valid, 1'b0);
        chk({name, ".resp_rdata"}, resp_rdata, 32'd0);
        chk1({name, ".resp_err"}, resp_err, 1'b0);
        chk({name, ".mem_raddr"}, mem_raddr, 32'd0);
        chk({name, ".mem_waddr"}, mem_waddr, 32'd0);
        chk({name, ".mem_wdata"}, mem_wdata, 32'd0);
        chk1({name, ".mem_wen"}, mem_wen, 1'b0);
    endtask

    // One request from an idle negedge; reports latency and write activity.
    task automatic expect_req(input string name, input logic we, input logic [1:0] sz,
                              input logic u, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] e_rd, input logic e_err, input int e_lat,
                              input int e_wens, input int e_wcyc);
        int n, lat, wens, wcyc;
        logic [31:0] wa;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        lat = 1; wens = 0; wcyc = 0; wa = 32'hFFFFFFFF;
        while (!resp_valid && lat < 10) begin
            if (mem_wen) begin wens++; wcyc = lat; wa = mem_waddr; end
            @(negedge clk);
            lat++;
        end
        if (mem_wen) wens++;
        chk({name, ".latency"}, lat, e_lat);
        chk({name, ".rdata"}, resp_rdata, e_rd);
        chk1({name, ".err"}, resp_err, e_err);
        chk({name, ".wen_count"}, wens, e_wens);
        if (e_wens != 0) begin
            chk({name, ".wen_cycle"}, wcyc, e_wcyc);
            chk({name, ".waddr"}, wa, a >> 2);
        end
        @(negedge clk);
    endtask

    initial begin
        int n, saw, wens, resps;
        rst_n = 1'b0; seeding = 1'b1; chk_en = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        seeding = 1'b0;
        @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        expect_req("sw4",  1, 2'd2, 0, 32'h4, 32'h80FF7F01, 32'h0, 0, 2, 1, 1);
        chk("sw4.mem", env_mem[1], 32'h80FF7F01);
        expect_req("lw4",  0, 2'd2, 0, 32'h4, 32'h0, 32'h80FF7F01, 0, 3, 0, 0);
        expect_req("lb7",  0, 2'd0, 0, 32'h7, 32'h0, 32'hFFFFFF80, 0, 3, 0, 0);
        expect_req("lbu7", 0, 2'd0, 1, 32'h7, 32'h0, 32'h00000080, 0, 3, 0, 0);
        expect_req("lh6",  0, 2'd1, 0, 32'h6, 32'h0, 32'hFFFF80FF, 0, 3, 0, 0);
        expect_req("lhu4", 0, 2'd1, 1, 32'h4, 32'h0, 32'h00007F01, 0, 3, 0, 0);

        expect_req("sw4b", 1, 2'd2, 0, 32'h4, 32'h11223344, 32'h0, 0, 2, 1, 1);
        expect_req("sb5",  1, 2'd0, 0, 32'h5, 32'h000000AB, 32'h0, 0, 4, 1, 3);
        chk("sb5.mem", env_mem[1], 32'h1122AB44);
        expect_req("sh6",  1, 2'd1, 0, 32'h6, 32'h0000BEEF, 32'h0, 0, 4, 1, 3);
        chk("sh6.mem", env_mem[1], 32'hBEEFAB44);

        expect_req("lh3",   0, 2'd1, 0, 32'h3,  32'h0, 32'h0, 1, 1, 0, 0);
        expect_req("sw6",   1, 2'd2, 0, 32'h6,  32'h12345678, 32'h0, 1, 1, 0, 0);
        expect_req("size3", 0, 2'd3, 0, 32'h8,  32'h0, 32'h0, 1, 1, 0, 0);
        expect_req("lw40",  0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 1, 1, 0, 0);
        chk("err.mem", env_mem[1], 32'hBEEFAB44);

        // Second request held pending through a read-modify-write.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h4; req_wdata = 32'h00000055;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h4; req_wdata = $urandom;
        n = 1; saw = 0;
        while (!req_ready && n < 20) begin
            if (resp_valid) saw = n;
            @(negedge clk);
            n++;
        end
        chk("busy.ready_cycle", n, 5);
        chk("busy.first_resp", saw, 4);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 10) begin @(negedge clk); n++; end
        chk("busy.second_lat", n, 3);
        chk("busy.second_rdata", resp_rdata, 32'hBEEFAB55);
        @(negedge clk);

        // Reset during RD2 of a byte store.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h5; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_outputs("midrst");
        wens = 0; resps = 0;
        repeat (6) begin
            if (mem_wen) wens++;
            if (resp_valid) resps++;
            @(negedge clk);
        end
        chk("midrst.wen_count", wens, 0);
        chk("midrst.resp_count", resps, 0);
        chk("midrst.mem", env_mem[1], 32'hBEEFAB55);

        // Random traffic, including occasional resets at arbitrary points.
        for (int c = 0; c < 4000; c++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            req_valid    = ($urandom_range(0, 3) != 0);
            req_we       = 1'($urandom_range(0, 1));
            req_size     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            req_unsigned = 1'($urandom_range(0, 1));
            req_addr     = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 32'h4F);
            req_wdata    = $urandom;
            @(negedge clk);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 16; i++) chk($sformatf("final.mem[%0d]", i), env_mem[i], model_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the execute stage and the word-addressed data memory (`MEM`). Accepts one byte-addressed load or store at a time, converts it to 32-bit word accesses, and returns sign- or zero-extended load data. Byte and halfword stores are done as read-modify-write. Misaligned, out-of-range and illegal-size requests are rejected without touching memory.

## Interface

Parameters:
- `MEM_AW`, default 30: word-address width of the attached memory. Legal word addresses are 0 .. 2^MEM_AW−1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. 0 for stores and errors.
- `resp_err` out 1: request was rejected. Valid with `resp_valid`.
- `mem_raddr` out 32: word read address to memory.
- `mem_rdata` in 32: read data from memory.
- `mem_waddr` out 32: word write address.
- `mem_wdata` out 32: word write data.
- `mem_wen` out 1: write enable.

## Operation

- States: IDLE, RD1, RD2, WR, RESP.
- A request is accepted when `req_valid & req_ready` is sampled at a rising edge. `req_ready` = 1 only in IDLE. While busy, all `req_*` inputs are ignored.
- On accept, `req_*` is registered. Word address = `req_addr[31:2]`, zero-extended to 32 bits. `mem_raddr` and `mem_waddr` both drive this registered word address in every state.
- Error checks at accept: any one of the following gives `resp_err` = 1, IDLE→RESP, no memory access, `resp_rdata` = 0.
  - `req_size` = 11.
  - Half access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 0.
  - `addr[31:2]` ≥ 2^MEM_AW.
- Transitions:
  - Word store: IDLE→WR.
  - Load or sub-word store: IDLE→RD1.
  - RD1→RD2.
  - At the end of RD2, capture `mem_rdata`. Load → RESP. Sub-word store → WR.
  - WR→RESP.
  - RESP→IDLE.
- Lanes are little-endian. Byte lane = `addr[1:0]` (bits 8·lane+7 .. 8·lane). Half lane = `addr[1]` (0 → [15:0], 1 → [31:16]).
- Load extraction: select the lane, then sign- or zero-extend per `req_unsigned`. A word load returns the word unchanged.
- Sub-word store merge: captured word with only the selected lane replaced by `req_wdata[7:0]` or `req_wdata[15:0]`. Word store: `mem_wdata` = `req_wdata`.
- `mem_wen` = 1 only in WR, for exactly one cycle per store.

## Timing

Cycle 0 is the accept cycle.
- Error: `resp_valid` in cycle 1.
- Word store: `mem_wen` in cycle 1, `resp_valid` in cycle 2.
- Load: read address stable in cycles 1–2, data sampled at the end of cycle 2, `resp_valid` in cycle 3.
- Sub-word store: `mem_wen` in cycle 3, `resp_valid` in cycle 4.
- `req_ready` returns to 1 the cycle after RESP. Back-to-back throughput is therefore latency + 1 cycles.
- `resp_rdata` and `resp_err` are registered, and hold their value until the next RESP.
- Reset (`rst_n` low at a rising edge, in any state, including mid-RMW): state → IDLE. All outputs and internal registers → 0, except `req_ready`, which is 1 from the first cycle after reset. A store cut off before WR never writes memory. A store in WR when reset is sampled completes its one write.
- No memory write is ever issued for an erroring request or a load.

## Test plan

- Word store then load: store 0x80FF7F01 to byte address 0x4, then LW 0x4.
  - Store: `mem_waddr` = 1 and `mem_wen` for one cycle in cycle 1; `resp_valid` in cycle 2, `resp_err` = 0.
  - Load: `resp_rdata` = 0x80FF7F01 in cycle 3.
- Sub-word loads from word 1 = 0x80FF7F01:
  - LB 0x7 → 0xFFFFFF80; LBU 0x7 → 0x00000080.
  - LH 0x6 → 0xFFFF80FF; LHU 0x4 → 0x00007F01.
- Read-modify-write: word 1 = 0x11223344.
  - SB 0x5, data 0x000000AB → written word 0x1122AB44.
  - SH 0x6, data 0x0000BEEF → written word 0xBEEFAB44.
  - Exactly one `mem_wen` per store, in cycle 3.
- Errors, each giving `resp_err` = 1, `resp_rdata` = 0 in cycle 1, no `mem_wen`:
  - LH 0x3.
  - SW 0x6.
  - `req_size` = 11.
  - With MEM_AW = 4: LW 0x40.
- Busy behaviour: hold `req_valid` high with a second request during an RMW. `req_ready` = 0 until the cycle after RESP; the second request is accepted exactly then and completes normally.
- Reset mid-operation: assert `rst_n` = 0 during RD2 of an SB.
  - No `mem_wen` and no `resp_valid` afterwards.
  - All outputs 0, `req_ready` = 1 after release; the memory word is unchanged.
